led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter PRESCALE_W, default 20, width of the tick prescaler; one tick every 2^PRESCALE_W enabled clock cycles.
REQ-002 osc_clk  input  1  sole clock, on-chip oscillator output; all registers are posedge osc_clk.
REQ-003 nreset  input  1  synchronous, active-low reset.
REQ-004 mode_btn  input  1  raw push-button, asynchronous to osc_clk.
REQ-005 run  input  1  1 = sequencing advances, 0 = freeze current pattern.
REQ-006 LED  output  8  registered LED drive, bit 7 = leftmost.
REQ-007 mode  output  2  current display mode (OFF=0, COUNT=1, SCAN=2, BLINK=3).

Function
REQ-008 Prescaler SHALL increment while run=1 and hold while run=0; tick SHALL pulse for one cycle when prescaler is all-ones and run=1; prescaler wraps to 0.
REQ-009 mode_btn SHALL pass a two-flop synchroniser then rising-edge detect; each detected edge is one-cycle btn_evt, 3 cycles after the input rises.
REQ-010 Mode FSM SHALL advance on btn_evt: OFF->COUNT->SCAN->BLINK->OFF; btn_evt is honoured regardless of run.
REQ-011 On a mode change the pattern register SHALL load the new mode's initial value, prescaler clears to 0, and SCAN direction sets to left, all in the same cycle.
REQ-012 OFF: pattern = 0x00, tick ignored.
REQ-013 COUNT: initial 0x00; +1 per tick, 0xFF wraps to 0x00.
REQ-014 SCAN: initial 0x01; per tick shift one position in current direction; at 0x80 direction becomes right, at 0x01 becomes left, the reversal taking effect on the same tick that reaches the end (0x40->0x80 then next tick 0x40); pattern always one-hot.
REQ-015 BLINK: initial 0xFF; toggles 0xFF<->0x00 per tick.
REQ-016 tick and btn_evt in the same cycle: btn_evt wins, tick is discarded.
REQ-017 LED SHALL equal the pattern register (optionally gated per REQ-021); update visible one cycle after the tick/event edge that caused it.
REQ-018 mode output SHALL reflect the FSM state register directly.

Reset
REQ-019 nreset=0 sampled at a clock edge SHALL force: mode=OFF, pattern=0x00, LED=0x00, prescaler=0, direction=left, synchroniser and edge flops=0; reset takes priority over all events including mid-sequence.
REQ-020 First btn_evt after reset release SHALL select COUNT; a button held through reset SHALL NOT generate an event on release.

Configuration
REQ-021 With LED_PWM_EN defined: extra input brightness[2:0]; free-running 3-bit pwm_cnt; LED = pattern when pwm_cnt <= brightness else 0x00 (brightness 7 = always on, 0 = 1/8 duty); pwm_cnt resets to 0.
REQ-022 Without LED_PWM_EN: brightness port and pwm_cnt absent; LED = pattern at full duty.

Structure
REQ-023 Package led_seq_pkg SHALL hold the mode_t enum (2-bit), initial-pattern constants per mode, and SCAN end constants 0x01/0x80.
REQ-024 Sub-module btn_sync_edge SHALL implement synchroniser plus rising-edge detect (ports osc_clk, nreset, btn_in, evt); everything else in led_sequencer.

Verification (PRESCALE_W=2, tick every 4 cycles)
REQ-025 Reset, run=1, pulse mode_btn once -> mode=1, LED 0x00,0x01,0x02... one step per 4 cycles; after 256 ticks LED returns to 0x00.
REQ-026 Three button pulses -> mode=3, LED 0xFF then alternates 0x00/0xFF every 4 cycles; fourth pulse -> mode=0, LED=0x00.
REQ-027 Two pulses (SCAN), run=1 for 16 ticks -> LED 0x01,0x02,...,0x80,0x40,...,0x02,0x01,0x02; never non-one-hot.
REQ-028 COUNT at LED=0x05, run=0 for 40 cycles -> LED stays 0x05; run=1 -> next increment after exactly 4 enabled cycles.
REQ-029 Button edge forced coincident with tick in COUNT -> mode=2, LED=0x01, no extra shift; nreset=0 mid-SCAN -> next cycle LED=0x00, mode=0.
REQ-030 LED_PWM_EN, BLINK on-phase, brightness=3 -> LED=0xFF for 4 of every 8 cycles; brightness=7 -> constant 0xFF.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer: display modes,
// per-mode initial patterns and the SCAN end positions.
package led_seq_pkg;

  localparam int unsigned LED_W = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [LED_W-1:0] OFF_INIT   = 8'h00;
  localparam logic [LED_W-1:0] COUNT_INIT = 8'h00;
  localparam logic [LED_W-1:0] SCAN_INIT  = 8'h01;
  localparam logic [LED_W-1:0] BLINK_INIT = 8'hFF;

  localparam logic [LED_W-1:0] SCAN_RIGHT_END = 8'h01;
  localparam logic [LED_W-1:0] SCAN_LEFT_END  = 8'h80;

  // Pattern loaded when a mode is entered.
  function automatic logic [LED_W-1:0] init_pattern(input mode_t m);
    logic [LED_W-1:0] p;
    case (m)
      MODE_COUNT: p = COUNT_INIT;
      MODE_SCAN:  p = SCAN_INIT;
      MODE_BLINK: p = BLINK_INIT;
      default:    p = OFF_INIT;
    endcase
    return p;
  endfunction

  // Mode cycle order for each button event.
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_OFF:   n = MODE_COUNT;
      MODE_COUNT: n = MODE_SCAN;
      MODE_SCAN:  n = MODE_BLINK;
      default:    n = MODE_OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for the mode button.
// evt pulses one cycle, three cycles after btn_in rises. An arm flag that
// is only set once a genuine low has been sampled keeps a button held
// through reset from producing an event on release.
module btn_sync_edge (
  input  logic osc_clk,
  input  logic nreset,
  input  logic btn_in,
  output logic evt
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic       armed_q;
  logic [1:0] valid_q;

  // Synchroniser, edge history, arm qualification and registered event.
  always_ff @(posedge osc_clk) begin
    if (!nreset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      valid_q <= 2'b00;
      evt     <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= {valid_q[0], 1'b1};
      if (valid_q[1] && !sync2_q) armed_q <= 1'b1;
      evt     <= armed_q & sync2_q & ~prev_q;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: button-cycled mode FSM (OFF/COUNT/SCAN/BLINK)
// stepping an 8-bit pattern once per prescaler tick.
// Optional feature macro: LED_PWM_EN adds a brightness input and a 3-bit
// PWM gate on the LED drive.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 20
) (
  input  logic             osc_clk,
  input  logic             nreset,
  input  logic             mode_btn,
  input  logic             run,
`ifdef LED_PWM_EN
  input  logic [2:0]       brightness,
`endif
  output logic [LED_W-1:0] LED,
  output logic [1:0]       mode
);

  mode_t                  mode_q, mode_d;
  dir_t                   dir_q, dir_d;
  logic [LED_W-1:0]       pattern_q, pattern_d;
  logic [PRESCALE_W-1:0]  presc_q, presc_d;
  logic [LED_W-1:0]       led_d_c;
  logic                   btn_evt;
  logic                   tick_c;

  btn_sync_edge u_btn (
    .osc_clk (osc_clk),
    .nreset  (nreset),
    .btn_in  (mode_btn),
    .evt     (btn_evt)
  );

  // Tick fires on the last prescaler count of an enabled cycle.
  assign tick_c = run && (presc_q == '1);

  // Next-state: mode change has priority and discards a coincident tick.
  always_comb begin
    mode_d    = mode_q;
    dir_d     = dir_q;
    pattern_d = pattern_q;
    presc_d   = presc_q;
    if (run) presc_d = presc_q + PRESCALE_W'(1);
    if (btn_evt) begin
      mode_d    = next_mode(mode_q);
      pattern_d = init_pattern(mode_d);
      dir_d     = DIR_LEFT;
      presc_d   = '0;
    end else if (tick_c) begin
      case (mode_q)
        MODE_COUNT: pattern_d = pattern_q + 8'd1;
        MODE_SCAN: begin
          if (dir_q == DIR_LEFT) begin
            pattern_d = {pattern_q[LED_W-2:0], 1'b0};
            if (pattern_d == SCAN_LEFT_END) dir_d = DIR_RIGHT;
          end else begin
            pattern_d = {1'b0, pattern_q[LED_W-1:1]};
            if (pattern_d == SCAN_RIGHT_END) dir_d = DIR_LEFT;
          end
        end
        MODE_BLINK: pattern_d = ~pattern_q;
        default:    pattern_d = OFF_INIT;
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [2:0] pwm_cnt_q;

  // Free-running PWM phase counter.
  always_ff @(posedge osc_clk) begin
    if (!nreset) pwm_cnt_q <= 3'd0;
    else         pwm_cnt_q <= pwm_cnt_q + 3'd1;
  end

  assign led_d_c = (pwm_cnt_q <= brightness) ? pattern_q : '0;
`else
  assign led_d_c = pattern_q;
`endif

  // State, pattern, prescaler and LED drive registers.
  always_ff @(posedge osc_clk) begin
    if (!nreset) begin
      mode_q    <= MODE_OFF;
      dir_q     <= DIR_LEFT;
      pattern_q <= OFF_INIT;
      presc_q   <= '0;
      LED       <= '0;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      pattern_q <= pattern_d;
      presc_q   <= presc_d;
      LED       <= led_d_c;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer with PRESCALE_W=2.
module tb_led_sequencer;

  logic       osc_clk  = 1'b0;
  logic       nreset   = 1'b0;
  logic       mode_btn = 1'b0;
  logic       run      = 1'b0;
`ifdef LED_PWM_EN
  logic [2:0] brightness = 3'd7;
`endif
  logic [7:0] LED;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 osc_clk = ~osc_clk;

  led_sequencer #(.PRESCALE_W(2)) dut (
    .osc_clk    (osc_clk),
    .nreset     (nreset),
    .mode_btn   (mode_btn),
    .run        (run),
`ifdef LED_PWM_EN
    .brightness (brightness),
`endif
    .LED        (LED),
    .mode       (mode)
  );

  typedef struct {
    int         presses;
    int         ticks;
    logic [1:0] exp_mode;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  // One-cycle button pulse; returns once the new mode's pattern is on LED.
  task automatic press();
    mode_btn = 1'b1;
    step(1);
    mode_btn = 1'b0;
    step(4);
  endtask

  task automatic do_reset();
    nreset   = 1'b0;
    run      = 1'b1;
    mode_btn = 1'b0;
    step(2);
    nreset = 1'b1;
    step(4);
  endtask

  logic [7:0] scan_exp [17];
  int         cnt;

  initial begin
    // Reset state
    step(3);
    check("reset_led", int'(LED), 'h00);
    check("reset_mode", int'(mode), 0);

    // {presses, ticks after last press, mode, LED}
    vecs[0]  = '{1, 0,  2'd1, 8'h00};
    vecs[1]  = '{1, 1,  2'd1, 8'h01};
    vecs[2]  = '{1, 5,  2'd1, 8'h05};
    vecs[3]  = '{1, 17, 2'd1, 8'h11};
    vecs[4]  = '{2, 0,  2'd2, 8'h01};
    vecs[5]  = '{2, 3,  2'd2, 8'h08};
    vecs[6]  = '{2, 7,  2'd2, 8'h80};
    vecs[7]  = '{2, 8,  2'd2, 8'h40};
    vecs[8]  = '{2, 14, 2'd2, 8'h01};
    vecs[9]  = '{2, 15, 2'd2, 8'h02};
    vecs[10] = '{2, 16, 2'd2, 8'h04};
    vecs[11] = '{3, 0,  2'd3, 8'hFF};
    vecs[12] = '{3, 1,  2'd3, 8'h00};
    vecs[13] = '{3, 2,  2'd3, 8'hFF};
    vecs[14] = '{4, 0,  2'd0, 8'h00};
    vecs[15] = '{4, 3,  2'd0, 8'h00};
    vecs[16] = '{5, 2,  2'd1, 8'h02};

    for (int i = 0; i < 17; i++) begin
      do_reset();
      for (int p = 0; p < vecs[i].presses; p++) press();
      step(4 * vecs[i].ticks);
      check($sformatf("vec%0d_mode", i), int'(mode), int'(vecs[i].exp_mode));
      check($sformatf("vec%0d_led", i), int'(LED), int'(vecs[i].exp_led));
    end

    // COUNT wraps after 256 ticks
    do_reset();
    press();
    step(255 * 4);
    check("count_255", int'(LED), 'hFF);
    step(4);
    check("count_wrap", int'(LED), 'h00);

    // SCAN bounce, one-hot at every tick
    scan_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    do_reset();
    press();
    press();
    for (int t = 0; t < 17; t++) begin
      check($sformatf("scan_t%0d", t), int'(LED), int'(scan_exp[t]));
      check("scan_onehot", int'($onehot(LED)), 1);
      step(4);
    end

    // BLINK alternates every 4 cycles, then fourth press returns to OFF
    do_reset();
    press();
    press();
    press();
    for (int c = 0; c < 16; c++) begin
      check($sformatf("blink_c%0d", c), int'(LED), (((c / 4) % 2) == 0) ? 'hFF : 'h00);
      step(1);
    end
    press();
    check("off_mode", int'(mode), 0);
    check("off_led", int'(LED), 'h00);

    // Freeze in COUNT at 0x05, then resume with the same phase
    do_reset();
    press();
    step(20);
    check("freeze_start", int'(LED), 'h05);
    run = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (LED == 8'h05) cnt++;
    end
    check("freeze_hold", cnt, 40);
    run = 1'b1;
    step(3);
    check("resume_3", int'(LED), 'h05);
    step(1);
    check("resume_4", int'(LED), 'h06);

    // Button event coincident with a tick in COUNT
    do_reset();
    press();
    step(8);
    step(3);
    press();
    check("coinc_mode", int'(mode), 2);
    check("coinc_led", int'(LED), 'h01);
    step(3);
    check("coinc_hold", int'(LED), 'h01);
    step(1);
    check("coinc_step", int'(LED), 'h02);

    // Reset mid-SCAN
    do_reset();
    press();
    press();
    step(12);
    check("midscan_led", int'(LED), 'h08);
    nreset = 1'b0;
    step(1);
    check("midrst_led", int'(LED), 'h00);
    check("midrst_mode", int'(mode), 0);
    nreset = 1'b1;
    step(4);

    // Button held through reset gives no event
    nreset   = 1'b0;
    mode_btn = 1'b1;
    step(3);
    nreset = 1'b1;
    step(10);
    check("held_mode", int'(mode), 0);
    mode_btn = 1'b0;
    step(4);
    press();
    check("after_held_mode", int'(mode), 1);

    // Button honoured while run=0, pattern frozen
    do_reset();
    run = 1'b0;
    press();
    check("run0_mode1", int'(mode), 1);
    press();
    check("run0_mode2", int'(mode), 2);
    check("run0_led", int'(LED), 'h01);
    step(10);
    check("run0_frozen", int'(LED), 'h01);

`ifdef LED_PWM_EN
    // PWM duty in a frozen BLINK on-phase
    do_reset();
    press();
    press();
    press();
    run = 1'b0;
    brightness = 3'd3;
    step(1);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step(1);
      if (LED == 8'hFF) cnt++;
    end
    check("pwm_b3", cnt, 4);
    brightness = 3'd7;
    step(1);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step(1);
      if (LED == 8'hFF) cnt++;
    end
    check("pwm_b7", cnt, 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
